// File: rtl/d_sram_like_bridge_if.sv
// Data-side sram-like bus bundle between the memory-stage bridge and the
// data memory / cache controller.
interface d_sram_like_bridge_if;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_size,
        output bus_addr,
        output bus_wdata,
        input  bus_addr_ok,
        input  bus_data_ok,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_size,
        input  bus_addr,
        input  bus_wdata,
        output bus_addr_ok,
        output bus_data_ok,
        output bus_rdata
    );
endinterface

// File: rtl/d_sram_like_bridge.sv
// Bridge from the memory stage's single-cycle access to the sram-like
// req/addr_ok/data_ok bus. One transaction in flight at a time; the core is
// stalled until the response arrives, and the read data is held in DONE
// until the global stall lets the pipeline advance.
module d_sram_like_bridge #(
    parameter bit RD_WORD_ALIGN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_en,
    input  logic [3:0]             data_wen,
    input  logic [31:0]            data_addr,
    input  logic [31:0]            data_wdata,
    input  logic                   longest_stall,
    output logic [31:0]            data_rdata,
    output logic                   d_stall,
    d_sram_like_bridge_if.master   sram
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } BridgeState;

    BridgeState  state;

    logic        heldWr;
    logic [1:0]  heldSize;
    logic [31:0] heldAddr;
    logic [31:0] heldWdata;

    logic        coreWr;
    logic [1:0]  coreSize;
    logic [31:0] coreAddr;

    // Byte-enable pattern to transfer size; malformed patterns fall back to word.
    function automatic logic [1:0] sizeFromWen(input logic [3:0] wen);
        logic [1:0] size;
        case (wen)
            4'b1111:                            size = 2'd2;
            4'b0011, 4'b1100:                   size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    // Request fields as the core presents them this cycle.
    always_comb begin
        coreWr   = |data_wen;
        coreSize = coreWr ? sizeFromWen(data_wen) : 2'd2;
        coreAddr = data_addr;
        if (!coreWr && RD_WORD_ALIGN) begin
            coreAddr = {data_addr[31:2], 2'b00};
        end
    end

    // Transaction FSM: captures the request, tracks the handshake and latches read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            heldWr     <= 1'b0;
            heldSize   <= 2'd0;
            heldAddr   <= 32'd0;
            heldWdata  <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_en) begin
                        heldWr    <= coreWr;
                        heldSize  <= coreSize;
                        heldAddr  <= coreAddr;
                        heldWdata <= data_wdata;
                        if (sram.bus_addr_ok && sram.bus_data_ok) begin
                            state <= DONE;
                            if (!coreWr) begin
                                data_rdata <= sram.bus_rdata;
                            end
                        end else if (sram.bus_addr_ok) begin
                            state <= WAIT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (sram.bus_addr_ok && sram.bus_data_ok) begin
                        state <= DONE;
                        if (!heldWr) begin
                            data_rdata <= sram.bus_rdata;
                        end
                    end else if (sram.bus_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (sram.bus_data_ok) begin
                        state <= DONE;
                        if (!heldWr) begin
                            data_rdata <= sram.bus_rdata;
                        end
                    end
                end
                DONE: begin
                    if (!longest_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus drive and stall: the first request cycle comes straight from the core,
    // retries come from the holding registers so the fields stay stable.
    always_comb begin
        sram.bus_req   = 1'b0;
        sram.bus_wr    = 1'b0;
        sram.bus_size  = 2'd0;
        sram.bus_addr  = 32'd0;
        sram.bus_wdata = 32'd0;
        d_stall        = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (data_en) begin
                        sram.bus_req   = 1'b1;
                        sram.bus_wr    = coreWr;
                        sram.bus_size  = coreSize;
                        sram.bus_addr  = coreAddr;
                        sram.bus_wdata = data_wdata;
                        d_stall        = 1'b1;
                    end
                end
                REQ: begin
                    sram.bus_req   = 1'b1;
                    sram.bus_wr    = heldWr;
                    sram.bus_size  = heldSize;
                    sram.bus_addr  = heldAddr;
                    sram.bus_wdata = heldWdata;
                    d_stall        = 1'b1;
                end
                WAIT: begin
                    d_stall = 1'b1;
                end
                default: begin
                    d_stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Directed bench for the data-side sram-like bridge: reads, stores of each
// size, delayed handshakes, held DONE under global stall, stray data_ok and
// asynchronous reset in the middle of a transaction.
module tb_d_sram_like_bridge;

    logic        clk;
    logic        rst;
    logic        data_en;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        longest_stall;
    logic [31:0] data_rdata;
    logic        d_stall;

    int checks;
    int errors;

    d_sram_like_bridge_if busIf ();

    d_sram_like_bridge #(.RD_WORD_ALIGN(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_en       (data_en),
        .data_wen      (data_wen),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .longest_stall (longest_stall),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .sram          (busIf.master)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The core must never present a byte-enable pattern the bus cannot express.
    always @(negedge clk) begin
        if (!rst && data_en && !(data_wen inside {4'b0000, 4'b1111, 4'b0011, 4'b1100,
                                                  4'b0001, 4'b0010, 4'b0100, 4'b1000})) begin
            $error("[TB] illegal byte-enable pattern %b from core", data_wen);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic aok, input logic dok,
                                 input logic [31:0] rdata, input logic ls);
        data_en           = en;
        data_wen          = wen;
        data_addr         = addr;
        data_wdata        = wdata;
        busIf.bus_addr_ok = aok;
        busIf.bus_data_ok = dok;
        busIf.bus_rdata   = rdata;
        longest_stall     = ls;
        #1;
    endtask

    task automatic checkRequest(input string tag, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
        checkOutput({tag, ".req"},   32'(busIf.bus_req), 32'd1);
        checkOutput({tag, ".wr"},    32'(busIf.bus_wr), 32'(wr));
        checkOutput({tag, ".size"},  32'(busIf.bus_size), 32'(size));
        checkOutput({tag, ".addr"},  busIf.bus_addr, addr);
        checkOutput({tag, ".wdata"}, busIf.bus_wdata, wdata);
        checkOutput({tag, ".stall"}, 32'(d_stall), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        #1;
        checkOutput("rst.req",   32'(busIf.bus_req), 32'd0);
        checkOutput("rst.addr",  busIf.bus_addr, 32'd0);
        checkOutput("rst.stall", 32'(d_stall), 32'd0);
        checkOutput("rst.rdata", data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Read with addr_ok immediately and data_ok two cycles later.
        applyStimulus(1'b1, 4'b0000, 32'h8000_1006, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        checkRequest("rd1", 1'b0, 2'd2, 32'h8000_1004, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h8000_1006, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("rd1.waitReq",   32'(busIf.bus_req), 32'd0);
        checkOutput("rd1.waitStall", 32'(d_stall), 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h8000_1006, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("rd1.dataStall", 32'(d_stall), 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h8000_1006, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("rd1.doneStall", 32'(d_stall), 32'd0);
        checkOutput("rd1.doneReq",   32'(busIf.bus_req), 32'd0);
        checkOutput("rd1.rdata",     data_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("rd1.idleStall", 32'(d_stall), 32'd0);
        @(negedge clk);

        // Byte store with addr_ok three cycles late; core inputs wobble meanwhile.
        applyStimulus(1'b1, 4'b0100, 32'h0000_1002, 32'h00AB_0000, 1'b0, 1'b0, 32'd0, 1'b0);
        checkRequest("sb.c0", 1'b1, 2'd0, 32'h0000_1002, 32'h00AB_0000);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h5555_5555, (i == 3), 1'b0, 32'd0, 1'b0);
            checkRequest($sformatf("sb.c%0d", i), 1'b1, 2'd0, 32'h0000_1002, 32'h00AB_0000);
        end
        @(negedge clk);
        applyStimulus(1'b1, 4'b0100, 32'h0000_1002, 32'h00AB_0000, 1'b0, 1'b1, 32'h5555_5555, 1'b0);
        checkOutput("sb.waitReq",   32'(busIf.bus_req), 32'd0);
        checkOutput("sb.waitStall", 32'(d_stall), 32'd1);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0100, 32'h0000_1002, 32'h00AB_0000, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("sb.doneStall", 32'(d_stall), 32'd0);
        checkOutput("sb.rdataKept", data_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Half then word store, both acknowledged fully in the request cycle.
        applyStimulus(1'b1, 4'b1100, 32'h0000_2002, 32'h1234_0000, 1'b1, 1'b1, 32'd0, 1'b0);
        checkRequest("sh", 1'b1, 2'd1, 32'h0000_2002, 32'h1234_0000);
        @(negedge clk);
        applyStimulus(1'b1, 4'b1100, 32'h0000_2002, 32'h1234_0000, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("sh.doneStall", 32'(d_stall), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'b1111, 32'h0000_3000, 32'h0BAD_F00D, 1'b1, 1'b1, 32'd0, 1'b0);
        checkRequest("sw", 1'b1, 2'd2, 32'h0000_3000, 32'h0BAD_F00D);
        @(negedge clk);
        applyStimulus(1'b1, 4'b1111, 32'h0000_3000, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("sw.doneStall", 32'(d_stall), 32'd0);
        checkOutput("sw.doneReq",   32'(busIf.bus_req), 32'd0);
        @(negedge clk);

        // Read completes while the global stall holds DONE for four more cycles.
        applyStimulus(1'b1, 4'b0000, 32'h0000_4008, 32'd0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
        checkRequest("rd2", 1'b0, 2'd2, 32'h0000_4008, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, 4'b0000, 32'h0000_4008, 32'd0, 1'b0, 1'b0, 32'hBAD0_BAD0, (i != 5));
            checkOutput($sformatf("rd2.hold%0d.req", i),   32'(busIf.bus_req), 32'd0);
            checkOutput($sformatf("rd2.hold%0d.stall", i), 32'(d_stall), 32'd0);
            checkOutput($sformatf("rd2.hold%0d.rdata", i), data_rdata, 32'hCAFE_F00D);
        end
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h0000_5000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkRequest("rd3.c0", 1'b0, 2'd2, 32'h0000_5000, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h0000_5000, 32'd0, 1'b1, 1'b1, 32'h1111_2222, 1'b0);
        checkRequest("rd3.c1", 1'b0, 2'd2, 32'h0000_5000, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h0000_5000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("rd3.rdata", data_rdata, 32'h1111_2222);
        checkOutput("rd3.doneStall", 32'(d_stall), 32'd0);
        @(negedge clk);

        // Stray data_ok in IDLE must not touch the read data.
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        checkOutput("stray.req",   32'(busIf.bus_req), 32'd0);
        checkOutput("stray.rdata", data_rdata, 32'h1111_2222);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("stray.rdataAfter", data_rdata, 32'h1111_2222);
        checkOutput("stray.stall",      32'(d_stall), 32'd0);
        @(negedge clk);

        // Reset asserted while waiting for data, then a fresh read.
        applyStimulus(1'b1, 4'b0000, 32'h0000_6000, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        checkRequest("rd4", 1'b0, 2'd2, 32'h0000_6000, 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h0000_6000, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("rd4.waitStall", 32'(d_stall), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst.req",   32'(busIf.bus_req), 32'd0);
        checkOutput("arst.stall", 32'(d_stall), 32'd0);
        checkOutput("arst.rdata", data_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1, 32'h9999_9999, 1'b0);
        checkOutput("arst.lateReq", 32'(busIf.bus_req), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 4'b0000, 32'h0000_7000, 32'd0, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
        checkOutput("arst.lateRdata", data_rdata, 32'd0);
        checkRequest("rd5", 1'b0, 2'd2, 32'h0000_7000, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("rd5.rdata", data_rdata, 32'hA5A5_A5A5);
        checkOutput("rd5.stall", 32'(d_stall), 32'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
